// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: single-outstanding word fetch, prefetch queue,
// decode-facing output register with stall hold and redirect flush.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic [2:0]  queue_count_o
);

  localparam int          PW      = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic           req_q, req_d;
  logic [31:0]    addr_q, addr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]     count_q, count_d;
  logic [31:0]    if_pc_q, if_pc_d;
  logic [31:0]    if_inst_q, if_inst_d;
  logic           if_valid_q, if_valid_d;
  logic [31:0]    q_pc_q   [DEPTH];
  logic [31:0]    q_inst_q [DEPTH];

  logic resp_ok;
  logic push;
  logic pop;
  logic bypass;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    push       = 1'b0;
    pop        = 1'b0;
    bypass     = 1'b0;
    resp_ok    = (state_q == BUSY) && mem_ready_i && !branch_flag_i;

    unique case (state_q)
      IDLE: begin
        if (!branch_flag_i && (count_q < DEPTH_C)) begin
          state_d = BUSY;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (branch_flag_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ready_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (branch_flag_i) begin
      fetch_pc_d = {branch_target_i[31:2], 2'b00};
      count_d    = 3'd0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
    end else begin
      if (!stall_i) begin
        if (count_q != 3'd0) begin
          pop        = 1'b1;
          if_pc_d    = q_pc_q[rd_ptr_q];
          if_inst_d  = q_inst_q[rd_ptr_q];
          if_valid_d = 1'b1;
        end else if (resp_ok) begin
          bypass     = 1'b1;
          if_pc_d    = addr_q;
          if_inst_d  = mem_rdata_i;
          if_valid_d = 1'b1;
        end else begin
          if_inst_d  = NOP_INST;
          if_valid_d = 1'b0;
        end
      end
      push = resp_ok && !bypass;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= 3'd0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[wr_ptr_q]   <= addr_q;
      q_inst_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign if_pc_o       = if_pc_q;
  assign if_inst_o     = if_inst_q;
  assign if_valid_o    = if_valid_q;
  assign queue_count_o = count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed scenarios with a
// latency-programmable memory model and a decoupled output monitor.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic [2:0]  queue_count_o;

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];
  logic        mon_en;
  logic        upd;
  logic [31:0] e_pc;

  logic        mem_auto;
  int          lat;
  int          m_cnt;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        man_ready;
  logic [31:0] man_rdata;

  inst_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ready_i     (mem_ready_i),
    .mem_rdata_i     (mem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o),
    .queue_count_o   (queue_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign mem_ready_i = mem_auto ? m_ready : man_ready;
  assign mem_rdata_i = mem_auto ? m_rdata : man_rdata;

  // Memory model: answers lat cycles after it first sees the request.
  always @(negedge clk) begin
    if (!rst || !mem_auto) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (m_ready) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (mem_req_o) begin
      if (m_cnt >= lat) begin
        m_ready = 1'b1;
        m_rdata = memf(mem_addr_o);
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_cnt = 0;
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks = checks + 1;
    if (a !== e) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  always @(posedge clk) begin
    upd = rst && !stall_i && !branch_flag_i;
    #1;
    if (mon_en && upd && if_valid_o) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL mon_extra got=%h exp=none", if_pc_o);
      end else begin
        e_pc = exp_q.pop_front();
        chk("mon_pc", if_pc_o, e_pc);
        chk("mon_inst", if_inst_o, memf(e_pc));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b0;
    stall_i       = 1'b0;
    branch_flag_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(n, exp_q.size(), 0);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    mon_en          = 1'b0;
    mem_auto        = 1'b1;
    lat             = 0;
    man_ready       = 1'b0;
    man_rdata       = 32'd0;
    rst             = 1'b0;
    stall_i         = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_pc", if_pc_o, 0);
    chk("rst_inst", if_inst_o, 32'h13);
    chk("rst_valid", if_valid_o, 0);
    chk("rst_count", queue_count_o, 0);

    // Sequential stream plus stall hold
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    mon_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_valid", if_valid_o, 0);
    chk("pre_inst", if_inst_o, 32'h13);
    for (int i = 0; i < 50 && !(if_valid_o && if_pc_o == 32'h4); i++)
      @(negedge clk);
    chk("reach_pc4", if_pc_o, 32'h4);
    stall_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall_pc", if_pc_o, 32'h4);
    chk("stall_valid", if_valid_o, 1);
    chk("stall_count", queue_count_o, 2);
    chk("stall_req", mem_req_o, 0);
    stall_i = 1'b0;
    drain("seq_drain");

    // Redirect while BUSY, slow memory
    lat = 2;
    do_reset();
    exp_q = '{32'h100, 32'h104};
    mon_en = 1'b1;
    @(negedge clk);
    chk("br_busy_req", mem_req_o, 1);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0102;
    @(negedge clk);
    branch_flag_i = 1'b0;
    chk("br_drop_req", mem_req_o, 1);
    chk("br_drop_addr", mem_addr_o, 32'h0);
    chk("br_drop_valid", if_valid_o, 0);
    for (int i = 0; i < 20 && mem_req_o; i++) @(negedge clk);
    for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk);
    chk("br_new_req", mem_req_o, 1);
    chk("br_new_addr", mem_addr_o, 32'h100);
    drain("br_drain");

    // Redirect coincident with response under stall
    lat = 0;
    do_reset();
    stall_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bs_count1", queue_count_o, 1);
    @(negedge clk);
    chk("bs_req4", mem_addr_o, 32'h4);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0200;
    @(negedge clk);
    branch_flag_i = 1'b0;
    stall_i       = 1'b0;
    chk("bs_count0", queue_count_o, 0);
    chk("bs_valid", if_valid_o, 0);
    chk("bs_inst", if_inst_o, 32'h13);
    chk("bs_idle", mem_req_o, 0);
    exp_q = '{32'h200, 32'h204};
    mon_en = 1'b1;
    @(negedge clk);
    chk("bs_new_req", mem_req_o, 1);
    chk("bs_new_addr", mem_addr_o, 32'h200);
    drain("bs_drain");

    // fetch_pc wrap at top of address space
    do_reset();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFF_FFFE;
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    mon_en = 1'b1;
    @(negedge clk);
    branch_flag_i = 1'b0;
    chk("wr_idle", mem_req_o, 0);
    @(negedge clk);
    chk("wr_req", mem_req_o, 1);
    chk("wr_addr_top", mem_addr_o, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    chk("wr_req2", mem_req_o, 1);
    chk("wr_addr_zero", mem_addr_o, 32'h0);
    drain("wr_drain");

    // Async reset mid-request, then spurious response while IDLE
    lat = 3;
    for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk);
    chk("ar_busy", mem_req_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req", mem_req_o, 0);
    chk("ar_addr", mem_addr_o, 0);
    chk("ar_pc", if_pc_o, 0);
    chk("ar_inst", if_inst_o, 32'h13);
    chk("ar_valid", if_valid_o, 0);
    chk("ar_count", queue_count_o, 0);
    @(negedge clk);
    mem_auto  = 1'b0;
    man_ready = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    rst       = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    chk("sp_count", queue_count_o, 0);
    chk("sp_valid", if_valid_o, 0);
    chk("sp_req", mem_req_o, 1);
    chk("sp_addr", mem_addr_o, 32'h0);
    @(negedge clk);
    chk("sp_count2", queue_count_o, 0);
    chk("sp_valid2", if_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
